cordic_rot_pipe: RTL and testbench
==================================

CORDIC_ROT_PIPE -- requirements
Module: cordic_rot_pipe

Interface
REQ-001 Parameter WL, default 18, total sample word length in two's complement.
REQ-002 Parameter FRAC, default 10, fractional bits of x/y (Q(WL-FRAC).FRAC).
REQ-003 Parameter NSTAGE, default 7, micro-rotation stages; legal range 4..16; stage i shifts by i.
REQ-004 Parameter REG_EVERY, default 4, stages per pipeline group; legal range 1..NSTAGE.
REQ-005 Parameter KW, default 11, gain-constant width (unsigned, KW-1 fraction bits).
REQ-006 Parameter KN, default 11'b0_1001101101 (~0.6064), CORDIC gain-compensation constant.
REQ-007 Parameter TAG_W, default 4, width of side-band tag carried alongside each sample.
REQ-008 clk  in  1  single clock; all state updates on rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 in_valid  in  1  input sample present.
REQ-011 in_ready  out  1  block accepts a sample this cycle when high.
REQ-012 x_i, y_i  in  WL each  signed input vector.
REQ-013 pre_rot_i  in  1  enable +/-90 deg pre-rotation.
REQ-014 angle_pre_i  in  1  pre-rotation sense: 1 = +90 deg, 0 = -90 deg.
REQ-015 dir_i  in  NSTAGE  bit i = 1 rotates stage i counter-clockwise by atan(2^-i), 0 clockwise.
REQ-016 gain_en_i  in  1  1 = multiply result by KN, 0 = bypass gain.
REQ-017 tag_i  in  TAG_W  opaque tag, returned unchanged with the result.
REQ-018 out_valid  out  1  result present.
REQ-019 out_ready  in  1  downstream accepts result.
REQ-020 x_o, y_o  out  WL each  signed rotated vector.
REQ-021 tag_o  out  TAG_W  tag of the sample on x_o/y_o.

Function
REQ-022 Pre-rotation (combinational, group 0): pre_rot=1, angle_pre=1 -> (x,y)=(-y,x); pre_rot=1, angle_pre=0 -> (y,-x); pre_rot=0 -> unchanged.
REQ-023 Stage i with dir=1: x'=x-(y>>>i), y'=y+(x>>>i); dir=0: x'=x+(y>>>i), y'=y-(x>>>i); arithmetic shift, truncation.
REQ-024 Datapath internal width WL+2 (two guard bits, sign-extended at entry); no wrap inside the rotator for any legal input.
REQ-025 Stages partitioned into G=ceil(NSTAGE/REG_EVERY) groups; a register (data, valid, dir remainder, gain_en, tag) follows each group.
REQ-026 Output stage: gain_en=1 -> product internal*KN, round half-up at bit KW-1, saturate to WL; gain_en=0 -> saturate internal to WL; result registered into x_o/y_o.
REQ-027 Saturation limits: +(2^(WL-1)-1) and -2^(WL-1); no wrap-around on outputs.
REQ-028 Latency G+1 cycles from accepted input to out_valid, absent back-pressure (default: 3).
REQ-029 Global advance adv = !out_valid || out_ready; in_ready = adv; all pipeline registers load only when adv=1.
REQ-030 Sample accepted when in_valid && in_ready; in_valid with in_ready=0 is not captured (source holds).
REQ-031 Bubbles propagate as valid=0; out_valid never asserts for a cycle with no accepted sample behind it.
REQ-032 While out_valid && !out_ready: x_o, y_o, tag_o, out_valid hold stable; no sample dropped or duplicated.
REQ-033 Throughput one sample per cycle when out_ready held high.
REQ-034 Per-sample controls (pre_rot, angle_pre, dir, gain_en, tag) travel with their sample; changing them every cycle is legal.

Reset
REQ-035 rst=1 at a rising edge clears every valid bit, out_valid=0, x_o=0, y_o=0, tag_o=0; data registers may clear to 0.
REQ-036 in_ready=1 in the first cycle after rst deasserts; samples in flight at rst are discarded, none emerge later.
REQ-037 rst takes priority over adv and in_valid in the same cycle.

Verification
REQ-038 x=1024, y=0, pre_rot=0, dir=7'b1111111, gain_en=1, out_ready=1 -> after 3 cycles x_o=-160+/-3, y_o=1011+/-3 (99.0 deg).
REQ-039 x=1024, y=0, pre_rot=1, angle_pre=0, dir=1,0,1,0,1,0,1 (stage 0 first), gain_en=1 -> x_o=481+/-3, y_o=-904+/-3 (-61.97 deg).
REQ-040 x=y=0x1FFFF, dir all 1, gain_en=0 -> y_o=0x1FFFF (saturated), x_o in range, no wrap.
REQ-041 Stream 10 tagged samples with out_ready low 4 cycles mid-stream -> in_ready drops only when full, all 10 emerge in order, tags intact, outputs stable while stalled.
REQ-042 rst pulsed 1 cycle with 3 samples in flight -> out_valid=0, x_o=y_o=0 next cycle; no stale sample ever appears.
REQ-043 Random sweep 10^4 samples vs. bit-accurate model (NSTAGE 7 and 12, REG_EVERY 1/3/NSTAGE) -> exact match, latency G+1.

Source files
------------

// File: rtl/cordic_rot_pipe.sv
// cordic_rot_pipe: pipelined CORDIC vector rotator (rotation mode).
// An optional +/-90 degree pre-rotation is followed by NSTAGE shift-add
// micro-rotations and then an optional gain-compensation multiply with
// saturation. Each sample carries its own direction bits, gain enable and tag.
// The micro-rotations are split into groups of REG_EVERY stages, with a
// register after each group. A single global advance signal stalls the
// whole pipeline when the output is held.
module cordic_rot_pipe #(
  parameter int            WL        = 18,
  parameter int            FRAC      = 10,
  parameter int            NSTAGE    = 7,
  parameter int            REG_EVERY = 4,
  parameter int            KW        = 11,
  parameter logic [KW-1:0] KN        = KW'(11'b0_1001101101),
  parameter int            TAG_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WL-1:0]    x_i,
  input  logic signed [WL-1:0]    y_i,
  input  logic                    pre_rot_i,
  input  logic                    angle_pre_i,
  input  logic [NSTAGE-1:0]       dir_i,
  input  logic                    gain_en_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WL-1:0]    x_o,
  output logic signed [WL-1:0]    y_o,
  output logic [TAG_W-1:0]        tag_o
);

  // Two guard bits are enough: the pre-rotation can turn -2^(WL-1) into
  // +2^(WL-1), and the CORDIC gain (< 1.65) applied to a diagonal vector
  // stays below 2^(WL+1).
  localparam int IW = WL + 2;
  // Number of register groups along the rotator.
  localparam int G  = (NSTAGE + REG_EVERY - 1) / REG_EVERY;
  // Width of the gain product: internal word times the zero-extended constant.
  localparam int PW = IW + KW + 1;

  localparam logic signed [PW-1:0] SAT_HI = {{(PW-WL+1){1'b0}}, {(WL-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(PW-WL+1){1'b1}}, {(WL-1){1'b0}}};
  localparam logic signed [PW-1:0] KN_S   = PW'({1'b0, KN});
  localparam logic signed [PW-1:0] RND    = {{(PW-KW+1){1'b0}}, 1'b1, {(KW-2){1'b0}}};

  // Reject parameter sets outside the supported range at elaboration.
  if (NSTAGE < 4 || NSTAGE > 16 || REG_EVERY < 1 || REG_EVERY > NSTAGE ||
      KW < 2 || FRAC < 0 || FRAC >= WL || TAG_W < 1) begin : g_param_check
    $error("cordic_rot_pipe: illegal parameter combination");
  end

  // Clamp a wide signed value into the WL-bit output range.
  function automatic logic signed [WL-1:0] sat_wl(input logic signed [PW-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[WL-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[WL-1:0];
    end else begin
      return v[WL-1:0];
    end
  endfunction

  // Multiply by KN (KW-1 fraction bits), then round half-up at bit KW-1.
  function automatic logic signed [PW-1:0] apply_gain(input logic signed [IW-1:0] v);
    logic signed [PW-1:0] prod;
    prod = PW'(v) * KN_S;
    prod = prod + RND;
    return prod >>> (KW - 1);
  endfunction

  // Global advance: the pipeline moves only when the output slot can be freed.
  logic adv;

  // Group registers (one entry per group) and their next values.
  logic signed [IW-1:0] x_q   [G];
  logic signed [IW-1:0] y_q   [G];
  logic signed [IW-1:0] x_d   [G];
  logic signed [IW-1:0] y_d   [G];
  logic                 vld_q [G];
  logic                 vld_d [G];
  logic [NSTAGE-1:0]    dir_q [G];
  logic [NSTAGE-1:0]    dir_d [G];
  logic                 gain_q [G];
  logic                 gain_d [G];
  logic [TAG_W-1:0]     tag_q [G];
  logic [TAG_W-1:0]     tag_d [G];

  // Output register and its next value.
  logic signed [WL-1:0] xo_q, xo_d;
  logic signed [WL-1:0] yo_q, yo_d;
  logic [TAG_W-1:0]     tago_q, tago_d;
  logic                 ovld_q, ovld_d;

  // Entry vector after sign extension and optional pre-rotation.
  logic signed [IW-1:0] ent_x, ent_y;

  assign adv      = !ovld_q || out_ready;
  assign in_ready = adv;

  // Sign-extend the input and apply the +/-90 degree pre-rotation.
  always_comb begin
    ent_x = IW'(x_i);
    ent_y = IW'(y_i);
    if (pre_rot_i) begin
      if (angle_pre_i) begin
        ent_x = -IW'(y_i);
        ent_y = IW'(x_i);
      end else begin
        ent_x = IW'(y_i);
        ent_y = -IW'(x_i);
      end
    end
  end

  // Micro-rotation groups: group g applies stages g*REG_EVERY .. up to the
  // next group boundary, fed by the entry vector (g = 0) or the register of
  // the previous group.
  always_comb begin
    logic signed [IW-1:0] cx, cy, tx;
    logic [NSTAGE-1:0]    cd;
    logic                 cv, cg;
    logic [TAG_W-1:0]     ct;
    cx = '0;
    cy = '0;
    tx = '0;
    cd = '0;
    cv = 1'b0;
    cg = 1'b0;
    ct = '0;
    for (int g = 0; g < G; g++) begin
      if (g == 0) begin
        cx = ent_x;
        cy = ent_y;
        cd = dir_i;
        cv = in_valid;
        cg = gain_en_i;
        ct = tag_i;
      end else begin
        cx = x_q[(g > 0) ? g - 1 : 0];
        cy = y_q[(g > 0) ? g - 1 : 0];
        cd = dir_q[(g > 0) ? g - 1 : 0];
        cv = vld_q[(g > 0) ? g - 1 : 0];
        cg = gain_q[(g > 0) ? g - 1 : 0];
        ct = tag_q[(g > 0) ? g - 1 : 0];
      end
      for (int s = 0; s < NSTAGE; s++) begin
        if (s / REG_EVERY == g) begin
          if (cd[s]) begin
            tx = cx - (cy >>> s);
            cy = cy + (cx >>> s);
          end else begin
            tx = cx + (cy >>> s);
            cy = cy - (cx >>> s);
          end
          cx = tx;
        end
      end
      x_d[g]    = cx;
      y_d[g]    = cy;
      dir_d[g]  = cd;
      vld_d[g]  = cv;
      gain_d[g] = cg;
      tag_d[g]  = ct;
    end
  end

  // Group valid bits: cleared by reset, advance with the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < G; g++) begin
        vld_q[g] <= 1'b0;
      end
    end else if (adv) begin
      for (int g = 0; g < G; g++) begin
        vld_q[g] <= vld_d[g];
      end
    end
  end

  // Group data and side-band: no reset needed, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int g = 0; g < G; g++) begin
        x_q[g]    <= x_d[g];
        y_q[g]    <= y_d[g];
        dir_q[g]  <= dir_d[g];
        gain_q[g] <= gain_d[g];
        tag_q[g]  <= tag_d[g];
      end
    end
  end

  // Output stage: optional gain with rounding, then saturation to WL bits.
  always_comb begin
    if (gain_q[G-1]) begin
      xo_d = sat_wl(apply_gain(x_q[G-1]));
      yo_d = sat_wl(apply_gain(y_q[G-1]));
    end else begin
      xo_d = sat_wl(PW'(x_q[G-1]));
      yo_d = sat_wl(PW'(y_q[G-1]));
    end
    tago_d = tag_q[G-1];
    ovld_d = vld_q[G-1];
  end

  // Output register: cleared by reset, holds while stalled, and loads data
  // only together with a valid sample so bubbles leave the last result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovld_q <= 1'b0;
      xo_q   <= '0;
      yo_q   <= '0;
      tago_q <= '0;
    end else if (adv) begin
      ovld_q <= ovld_d;
      if (ovld_d) begin
        xo_q   <= xo_d;
        yo_q   <= yo_d;
        tago_q <= tago_d;
      end
    end
  end

  assign out_valid = ovld_q;
  assign x_o       = xo_q;
  assign y_o       = yo_q;
  assign tag_o     = tago_q;

endmodule

// File: tb/tb_cordic_rot_pipe.sv
// Scoreboard bench for cordic_rot_pipe at default parameters (two register
// groups, three-cycle latency). The driver pushes expected results when a
// sample is accepted; a monitor pops and compares whenever a result is taken.
module tb_cordic_rot_pipe;

  localparam int WL  = 18;
  localparam int NS  = 7;
  localparam int TW  = 4;
  localparam int LAT = 3;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [WL-1:0] x_i, y_i;
  logic                 pre_rot_i, angle_pre_i;
  logic [NS-1:0]        dir_i;
  logic                 gain_en_i;
  logic [TW-1:0]        tag_i;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [WL-1:0] x_o, y_o;
  logic [TW-1:0]        tag_o;

  cordic_rot_pipe #(
    .WL(WL), .FRAC(10), .NSTAGE(NS), .REG_EVERY(4), .KW(11),
    .KN(11'b0_1001101101), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_i(x_i), .y_i(y_i), .pre_rot_i(pre_rot_i), .angle_pre_i(angle_pre_i),
    .dir_i(dir_i), .gain_en_i(gain_en_i), .tag_i(tag_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_o(x_o), .y_o(y_o), .tag_o(tag_o)
  );

  typedef struct {
    int          x;
    int          y;
    logic [TW-1:0] tag;
    int          acc;
    bit          lat;
    bit          tol;
    int          tx;
    int          ty;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   lat_ok  = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: pre-rotate, micro-rotate with arithmetic shifts, gain 621/1024
  // with half-up rounding, clamp to 18-bit two's complement.
  function automatic void model(input int xi, input int yi, input bit pre, input bit ang,
                                input bit [NS-1:0] d, input bit g,
                                output int xo, output int yo);
    longint x, y, t;
    x = xi;
    y = yi;
    if (pre) begin
      t = x;
      if (ang) begin x = -y; y = t; end
      else     begin x = y;  y = -t; end
    end
    for (int i = 0; i < NS; i++) begin
      if (d[i]) begin t = x - (y >>> i); y = y + (x >>> i); end
      else      begin t = x + (y >>> i); y = y - (x >>> i); end
      x = t;
    end
    if (g) begin
      x = (x * 621 + 512) >>> 10;
      y = (y * 621 + 512) >>> 10;
    end
    if (x > 131071) x = 131071;
    if (x < -131072) x = -131072;
    if (y > 131071) y = 131071;
    if (y < -131072) y = -131072;
    xo = int'(x);
    yo = int'(y);
  endfunction

  // Present one sample and wait (bounded) until it is accepted.
  task automatic send(input int xv, input int yv, input bit pre, input bit ang,
                      input bit [NS-1:0] d, input bit g, input logic [TW-1:0] tg,
                      input bit tol, input int tx, input int ty);
    exp_t e;
    bit   ok;
    @(negedge clk);
    x_i         = xv[WL-1:0];
    y_i         = yv[WL-1:0];
    pre_rot_i   = pre;
    angle_pre_i = ang;
    dir_i       = d;
    gain_en_i   = g;
    tag_i       = tg;
    in_valid    = 1'b1;
    model(xv, yv, pre, ang, d, g, e.x, e.y);
    e.tag = tg;
    e.lat = lat_ok;
    e.tol = tol;
    e.tx  = tx;
    e.ty  = ty;
    ok    = 1'b0;
    for (int w = 0; w < 100; w++) begin
      #4;
      if (in_ready) begin
        e.acc = cyc;
        q.push_back(e);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_accept: in_ready stayed 0 for tag %0d, required 1", tg);
    end
    @(posedge clk);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_all_emerged", int'(ok), 1);
  endtask

  // Monitor: just before each rising edge, compare any result being taken
  // and confirm outputs held stable across a stalled cycle.
  exp_t          me;
  bit            prev_stall = 1'b0;
  int            px, py;
  logic [TW-1:0] pt;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_hold", int'(out_valid), 1);
          check("stall_x_hold", int'(x_o), px);
          check("stall_y_hold", int'(y_o), py);
          check("stall_tag_hold", int'(tag_o), int'(pt));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: out_valid=1 tag=%0d x=%0d with no sample pending",
                     tag_o, x_o);
          end else begin
            me = q.pop_front();
            check("x_out", int'(x_o), me.x);
            check("y_out", int'(y_o), me.y);
            check("tag_out", int'(tag_o), int'(me.tag));
            if (me.lat) check("latency", cyc - me.acc, LAT);
            if (me.tol) begin
              check("x_near_ref", int'((int'(x_o) - me.tx) >= -3 && (int'(x_o) - me.tx) <= 3), 1);
              check("y_near_ref", int'((int'(y_o) - me.ty) >= -3 && (int'(y_o) - me.ty) <= 3), 1);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        px = int'(x_o);
        py = int'(y_o);
        pt = tag_o;
      end
    end
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    x_i         = '0;
    y_i         = '0;
    pre_rot_i   = 1'b0;
    angle_pre_i = 1'b0;
    dir_i       = '0;
    gain_en_i   = 1'b0;
    tag_i       = '0;
    out_ready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_x_o", int'(x_o), 0);
    check("rst_y_o", int'(y_o), 0);
    check("rst_tag_o", int'(tag_o), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", int'(in_ready), 1);

    // Directed vectors, back to back, out_ready high (hand references +/-3)
    send(1024, 0, 0, 0, 7'b1111111, 1, 4'h1, 1, -160, 1011);
    send(1024, 0, 1, 0, 7'b1010101, 1, 4'h2, 1, 481, -904);
    send(131071, 131071, 0, 0, 7'b1111111, 0, 4'h3, 1, -131072, 131071);
    send(-131072, -131072, 0, 0, 7'b1111111, 0, 4'h4, 1, 131071, -131072);
    send(300, -200, 1, 1, 7'b0000000, 0, 4'h5, 0, 0, 0);
    send(-500, 700, 0, 0, 7'b0110101, 1, 4'h6, 0, 0, 0);
    send(0, 0, 1, 1, 7'b1100110, 1, 4'h7, 1, 0, 0);
    send(-131072, 5, 1, 1, 7'b0000001, 0, 4'h8, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Tagged stream of 10 with a 4-cycle output stall in the middle
    lat_ok = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(100 * i - 400, 37 * i * i - 200, i[0], i[1], NS'(i * 13),
               (i % 3) != 0, TW'(i + 6), 0, 0, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    lat_ok = 1'b1;

    // Reset with three samples in flight: none may emerge afterwards
    @(negedge clk);
    out_ready = 1'b0;
    send(111, 222, 0, 0, 7'b1010101, 1, 4'hA, 0, 0, 0);
    send(-333, 444, 1, 0, 7'b0101010, 0, 4'hB, 0, 0, 0);
    send(555, -666, 1, 1, 7'b1111111, 1, 4'hC, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_x_o", int'(x_o), 0);
    check("midrst_y_o", int'(y_o), 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    repeat (15) @(negedge clk);

    // One more sample after the flush to confirm normal operation resumes
    send(1024, 0, 0, 0, 7'b1111111, 1, 4'hD, 1, -160, 1011);
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    check("queue_empty_at_end", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
